// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit owning the HI/LO pair: radix-2 shift-add
// multiply and restoring divide, one iteration per cycle, start/ready/done handshake.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk_cpu,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   rs,
  input  logic [WIDTH-1:0]   rt,
  input  logic               kill,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] hilo_q
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     m_q;      // multiplicand (mult) or divisor (div) magnitude
  logic [2*WIDTH-1:0]   acc_q;    // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic                 is_div_q, neg_q, rneg_q, dz_q, done_q;

  logic                 signed_op, rs_neg, rt_neg;
  logic [WIDTH-1:0]     rs_mag, rt_mag;
  logic                 accept_md, accept_mt, step, fix;

  assign signed_op = ~op[0];
  assign rs_neg    = signed_op & rs[WIDTH-1];
  assign rt_neg    = signed_op & rt[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs : rs;
  assign rt_mag    = rt_neg ? -rt : rt;

  assign ready     = (state_q == IDLE);
  assign busy      = ~ready;
  assign done      = done_q;
  assign accept_md = ready & start & ~kill & ~op[2];
  assign accept_mt = ready & start & ~kill & (op[2:1] == 2'b10);

  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    fix     = 1'b0;
    case (state_q)
      IDLE: if (accept_md) state_d = CALC;
      CALC: begin
        if (kill) state_d = IDLE;
        else begin
          step = 1'b1;
          if (cnt_q == CW'(1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        fix     = ~kill;
      end
      default: state_d = IDLE;
    endcase
  end

  // One shift-add multiply step
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // One restoring divide step; the extra top bit of the trial catches the borrow
  logic [WIDTH:0]       div_shift, div_diff;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_next;
  assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, m_q};
  assign div_rem   = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], ~div_diff[WIDTH]};

  // Sign fix-up; remainder follows the dividend, so divide-by-zero leaves HI = rs
  logic [2*WIDTH-1:0]   prod_s, fix_val;
  logic [WIDTH-1:0]     quo_s, rem_s;
  assign prod_s  = neg_q ? -acc_q : acc_q;
  assign quo_s   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_s   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  assign fix_val = is_div_q ? {rem_s, (dz_q ? {WIDTH{1'b1}} : quo_s)} : prod_s;

  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      hilo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept_md) begin
        cnt_q    <= CW'(WIDTH);
        m_q      <= op[1] ? rt_mag : rs_mag;
        acc_q    <= {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
        is_div_q <= op[1];
        neg_q    <= rs_neg ^ rt_neg;
        rneg_q   <= rs_neg;
        dz_q     <= op[1] & (rt == '0);
      end else if (step) begin
        cnt_q <= cnt_q - CW'(1);
        acc_q <= is_div_q ? div_next : mul_next;
      end
      if (accept_mt) begin
        if (op[0]) hilo_q[WIDTH-1:0]       <= rs;
        else       hilo_q[2*WIDTH-1:WIDTH] <= rs;
        done_q <= 1'b1;
      end
      if (fix) begin
        hilo_q <= fix_val;
        done_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Parametrised, multi-cycle multiply/divide unit that owns the HI/LO register pair. It replaces single-cycle combinational `*`, `/` and `%` with an iterative datapath: radix-2 shift-add multiply and restoring divide. A start/ready/done handshake lets the pipeline stall on `busy`, and `kill` lets a flush abandon an operation. It sits beside the ALU in the execute stage; the ALU keeps all single-cycle ops and reads `hilo_q` for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits. Legal values are 8 to 64, even.
- `clk_cpu` input, 1 bit: CPU clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request; sampled only when `ready`=1.
- `op` input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved.
- `rs` input, `WIDTH` bits: multiplicand/dividend; source for MTHI/MTLO.
- `rt` input, `WIDTH` bits: multiplier/divisor.
- `kill` input, 1 bit: flush; aborts any in-flight operation.
- `ready` output, 1 bit: unit idle, so `start` can be accepted.
- `busy` output, 1 bit: iterative operation in flight; pipeline stall request. Always equals `~ready`.
- `done` output, 1 bit: one-cycle pulse; `hilo_q` has just been updated.
- `hilo_q` output, 2·`WIDTH` bits: {HI, LO}.

## Operation
- Reset values: HI=0, LO=0, state IDLE, `ready`=1, `busy`=0, `done`=0, internal accumulators 0.
- FSM states: IDLE, CALC, FIX.
- IDLE → CALC: on `start` & op∈{0..3} & !`kill`.
  - Latch `|rs|`, `|rt|` (magnitudes for signed ops, raw values for unsigned).
  - Latch result-sign bits.
  - Load iteration counter with `WIDTH`.
- IDLE, op∈{4,5}: on `start` & !`kill`, write `rs` into HI (op 4) or LO (op 5) at that edge; `done` pulses next cycle; no state change.
- IDLE, op∈{6,7}: ignored; no done, no write.
- CALC: one iteration per cycle; counter decrements; leave for FIX when counter reaches 0 (exactly `WIDTH` CALC cycles).
  - Multiply: 2·`WIDTH` unsigned shift-add product of magnitudes.
  - Divide: restoring; `WIDTH`-bit quotient plus `WIDTH`-bit partial remainder, 1 extra bit for the trial subtract.
- FIX: one cycle; apply signs and write HI/LO; → IDLE with `done`=1.
  - Product is negated when sign(rs) XOR sign(rt) on MULT.
  - Quotient is negated when the signs differ on DIV.
  - Remainder takes the sign of the dividend on DIV.
- Result mapping: mult gives {HI,LO} = 2·`WIDTH` product. Div gives LO = quotient, HI = remainder.
- Divide by zero (divisor 0, DIV or DIVU): LO = all ones, HI = dividend (`rs` as given). Takes the full latency; no exception.
- Signed overflow (DIV of −2^(W−1) by −1): LO = −2^(W−1), HI = 0. This falls out of the magnitude datapath with no special case.
- `kill` while `busy` (CALC or FIX): next edge → IDLE, HI/LO unchanged, no `done`.
- `kill` with `start` in IDLE: kill wins; the request is dropped, including MTHI/MTLO.
- `start` while `busy`: ignored; the requester holds it until `ready`.
- Operand inputs are don't-care after the accepting edge.

## Timing
- Edge E0 samples an accepted mult/div `start`.
- `busy` goes high after E0.
- CALC iterations occur at E1..E`WIDTH`.
- FIX writes HI/LO at E(`WIDTH`+1).
- `done`=1 and `ready`=1 in the cycle following E(`WIDTH`+1). Total latency from start cycle to done cycle is `WIDTH`+2 cycles (34 for `WIDTH`=32).
- Back-to-back: `start` asserted in the `done` cycle is accepted at the next edge, so throughput is one op per `WIDTH`+2 cycles.
- MTHI/MTLO: written at E0; `done` in the following cycle; `busy` never rises.
- `hilo_q` changes only at an MTHI/MTLO accept edge or a FIX edge. It is a registered output: no combinational path from `rs`/`rt`.
- Async `reset` low mid-operation: immediate IDLE, HI/LO = 0, `done`=0. After release, first accept on the next edge with `start`.

## Test plan
- MULT, `rs`=0xFFFFFFFD (−3), `rt`=5 → `done` 34 cycles after start; `hilo_q` = 0xFFFFFFFF_FFFFFFF1; `busy` high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hilo_q` = 0xFFFFFFFE_00000001. Immediately follow with a back-to-back MTHI 0x12345678 in the done cycle → HI = 0x12345678, LO unchanged.
- DIV 7 / −2 → LO=0xFFFFFFFD, HI=0x00000001. DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 → LO=0xFFFFFFFF, HI=0x00000064. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload HI/LO=0xAAAA/0x5555 via MTHI/MTLO, then start DIVU and assert `kill` in CALC cycle 10 → no `done`, `ready` next cycle, `hilo_q` still 0x0000AAAA_00005555. Repeat with `reset` low in place of `kill` → `hilo_q`=0.
- `WIDTH`=8: MULT 0x80 × 0x80 → `hilo_q`=0x4000 with `done` 10 cycles after start. `start` with op=6 → no `done`, no write.
